// File: rtl/push_pop_seq_pkg.sv
// Shared definitions for the PUSH/POP sequencer: state encodings,
// architectural register indices, word size and register-select helper.
package push_pop_seq_pkg;

    typedef enum logic [2:0] {
        PPS_IDLE = 3'd0,
        PPS_CALC = 3'd1,
        PPS_XFER = 3'd2,
        PPS_SPWB = 3'd3,
        PPS_DONE = 3'd4
    } pps_state_t;

    localparam logic [3:0] SP_I = 4'd13;
    localparam logic [3:0] LR_I = 4'd14;
    localparam logic [3:0] PC_I = 4'd15;

    localparam int unsigned WORD_BYTES = 4;

    // List bit 8 addresses LR on the register-file read side.
    function automatic logic [3:0] push_reg_sel(input logic [3:0] idx);
        return (idx == 4'd8) ? LR_I : idx;
    endfunction

endpackage

// File: rtl/push_pop_seq_prio_enc9.sv
// prio_enc9: combinational lowest-set-bit encoder over a 9-bit list.
// Returns the index of the lowest set bit and a flag when no bit is set.
module prio_enc9 (
    input  logic [8:0] vec,
    output logic [3:0] idx,
    output logic       none
);

    // Scan upward and keep the first set bit found.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
            if (vec[i] && none) begin
                idx  = 4'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/push_pop_seq.sv
// push_pop_seq: multi-register PUSH/POP sequencer between the control unit
// and the data-memory port. One memory beat per listed register, ascending
// register number at ascending address, then a single SP write.
// Optional feature macro: PUSHPOP_LR_PC_EN (honour list bit 8 as LR/PC).
module push_pop_seq
    import push_pop_seq_pkg::*;
#(
    parameter int LIST_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_pop,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [31:0]       sp_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        addr_Rm,
    input  logic [31:0]       Rm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              ld_rd,
    output logic [3:0]        addr_Rd,
    output logic [31:0]       w_Rd,
    output logic              ld_pc,
    output logic              branch,
    output logic [31:0]       w_PC,
    output logic              ld_sp,
    output logic [31:0]       w_SP
);

    pps_state_t        state;
    logic              pop_q;
    logic [LIST_W-1:0] list_q;
    logic [31:0]       sp_q;
    logic [31:0]       sp_new_q;

    logic [LIST_W-1:0] list_cap;
    logic [LIST_W-1:0] list_rest;
    logic [3:0]        cnt_d;
    logic [31:0]       span_d;
    logic [31:0]       base_d;
    logic [3:0]        cur_idx;
    logic              cur_none;
    logic              in_xfer;
    logic              pop_ack;

    function automatic logic [3:0] popcount(input logic [LIST_W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < LIST_W; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

`ifdef PUSHPOP_LR_PC_EN
    assign list_cap = reg_list;
`else
    assign list_cap = reg_list & ~(LIST_W'(1) << 8);
`endif

    // Remaining list with the current (lowest) bit cleared.
    assign list_rest = list_q & (list_q - LIST_W'(1));
    assign cnt_d     = popcount(list_q);
    assign span_d    = 32'(cnt_d) * 32'(WORD_BYTES);
    assign base_d    = pop_q ? sp_q : (sp_q - span_d);

    prio_enc9 u_cur (
        .vec  (list_q),
        .idx  (cur_idx),
        .none (cur_none)
    );

    // Sequencer FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PPS_IDLE;
            pop_q    <= 1'b0;
            list_q   <= '0;
            sp_q     <= '0;
            sp_new_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            ld_sp    <= 1'b0;
            w_SP     <= '0;
        end else begin
            case (state)
                PPS_IDLE: begin
                    if (start) begin
                        pop_q  <= is_pop;
                        list_q <= list_cap;
                        sp_q   <= sp_in;
                        busy   <= 1'b1;
                        state  <= PPS_CALC;
                    end
                end
                PPS_CALC: begin
                    sp_new_q <= pop_q ? (sp_q + span_d) : base_d;
                    if (cnt_d == 4'd0) begin
                        done  <= 1'b1;
                        state <= PPS_DONE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= ~pop_q;
                        mem_addr <= base_d;
                        state    <= PPS_XFER;
                    end
                end
                PPS_XFER: begin
                    if (mem_ack && !cur_none) begin
                        list_q <= list_rest;
                        if (list_rest == '0) begin
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                            ld_sp    <= 1'b1;
                            w_SP     <= sp_new_q;
                            state    <= PPS_SPWB;
                        end else begin
                            mem_addr <= mem_addr + 32'(WORD_BYTES);
                        end
                    end
                end
                PPS_SPWB: begin
                    ld_sp <= 1'b0;
                    w_SP  <= '0;
                    done  <= 1'b1;
                    state <= PPS_DONE;
                end
                PPS_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= PPS_IDLE;
                end
                default: begin
                    state <= PPS_IDLE;
                end
            endcase
        end
    end

    // Register-select, write data and POP write-back decoded from the current beat.
    always_comb begin
        in_xfer   = (state == PPS_XFER);
        pop_ack   = in_xfer && pop_q && mem_ack && !cur_none;
        addr_Rm   = '0;
        mem_wdata = '0;
        ld_rd     = 1'b0;
        addr_Rd   = '0;
        w_Rd      = '0;
        ld_pc     = 1'b0;
        branch    = 1'b0;
        w_PC      = '0;
        if (in_xfer && !pop_q) begin
            addr_Rm   = push_reg_sel(cur_idx);
            mem_wdata = Rm;
        end
        if (pop_ack && !cur_idx[3]) begin
            ld_rd   = 1'b1;
            addr_Rd = cur_idx;
            w_Rd    = mem_rdata;
        end
`ifdef PUSHPOP_LR_PC_EN
        if (pop_ack && cur_idx == 4'd8) begin
            ld_pc  = 1'b1;
            branch = 1'b1;
            w_PC   = mem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_push_pop_seq.sv
// Directed bench for push_pop_seq; expectations follow the build's
// PUSHPOP_LR_PC_EN setting.
module tb_push_pop_seq;

`ifdef PUSHPOP_LR_PC_EN
    localparam int LRPC = 1;
`else
    localparam int LRPC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, is_pop;
    logic [8:0]  reg_list;
    logic [31:0] sp_in, Rm, mem_rdata;
    logic        mem_ack;
    logic        busy, done, mem_req, mem_we, ld_rd, ld_pc, branch, ld_sp;
    logic [3:0]  addr_Rm, addr_Rd;
    logic [31:0] mem_addr, mem_wdata, w_Rd, w_PC, w_SP;

    push_pop_seq #(.LIST_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .is_pop(is_pop),
        .reg_list(reg_list), .sp_in(sp_in), .busy(busy), .done(done),
        .addr_Rm(addr_Rm), .Rm(Rm), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ld_rd(ld_rd), .addr_Rd(addr_Rd), .w_Rd(w_Rd),
        .ld_pc(ld_pc), .branch(branch), .w_PC(w_PC), .ld_sp(ld_sp), .w_SP(w_SP)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [16];
    always_comb Rm = regs[addr_Rm];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];
    logic [3:0]  rq_idx[$];
    logic [31:0] rq_val[$];
    logic [31:0] pop_data [9];
    logic [31:0] sp_val, pc_val;
    int done_cyc, req_cyc, hold_err, sp_wr, pc_ld, stray;

    task automatic run_op(input logic pop, input logic [8:0] list, input logic [31:0] sp, input int wait_n);
        int cyc, waitcnt, beat;
        logic have_prev;
        logic [31:0] p_addr, p_data;
        logic p_we;
        bq_addr.delete(); bq_data.delete(); rq_idx.delete(); rq_val.delete();
        sp_val = '0; pc_val = '0;
        done_cyc = -1; req_cyc = 0; hold_err = 0; sp_wr = 0; pc_ld = 0; stray = 0;
        beat = 0; waitcnt = wait_n; have_prev = 1'b0;
        p_addr = '0; p_data = '0; p_we = 1'b0;
        start = 1'b1; is_pop = pop; reg_list = list; sp_in = sp;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 80) begin
            mem_ack   = mem_req && (waitcnt == 0);
            mem_rdata = (beat < 9) ? pop_data[beat] : '0;
            #1;
            if (mem_req) begin
                req_cyc++;
                if (have_prev && (mem_addr !== p_addr || mem_wdata !== p_data || mem_we !== p_we))
                    hold_err++;
                have_prev = 1'b1; p_addr = mem_addr; p_data = mem_wdata; p_we = mem_we;
            end
            if (branch !== ld_pc) stray++;
            if ((ld_rd || ld_pc) && !(mem_req && mem_ack && !mem_we)) stray++;
            if (mem_req && mem_ack) begin
                bq_addr.push_back(mem_addr);
                bq_data.push_back(mem_we ? mem_wdata : mem_rdata);
                if (ld_rd) begin
                    rq_idx.push_back(addr_Rd);
                    rq_val.push_back(w_Rd);
                end
                if (ld_pc) begin
                    pc_ld++;
                    pc_val = w_PC;
                end
                beat++;
                waitcnt = wait_n;
                have_prev = 1'b0;
            end else if (mem_req) begin
                waitcnt--;
            end
            if (ld_sp) begin
                sp_wr++;
                sp_val = w_SP;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        automatic logic [31:0] e1 [3] = '{32'h11, 32'h22, 32'hFFFF_FFFF};
        int n;
        int bad;
        logic [31:0] base;
        foreach (regs[i]) regs[i] = 32'h5A00_0000 | 32'(i);
        regs[0] = 32'h11; regs[1] = 32'h22; regs[3] = 32'h33; regs[14] = 32'hFFFF_FFFF;
        foreach (pop_data[i]) pop_data[i] = '0;
        rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = '0; sp_in = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctrl", {24'd0, busy, done, mem_req, mem_we, ld_rd, ld_pc, branch, ld_sp}, 32'd0);
        check_eq("rst_addr", mem_addr | {28'd0, addr_Rm} | {28'd0, addr_Rd}, 32'd0);
        check_eq("rst_data", mem_wdata | w_Rd | w_PC | w_SP, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // PUSH {R0,R1,LR}
        n = 2 + LRPC;
        base = 32'h2000_0100 - 32'(4 * n);
        run_op(1'b0, 9'h103, 32'h2000_0100, 0);
        check_eq("push1_beats", 32'(bq_addr.size()), 32'(n));
        for (int i = 0; i < n && i < bq_addr.size(); i++) begin
            check_eq($sformatf("push1_addr%0d", i), bq_addr[i], base + 32'(4 * i));
            check_eq($sformatf("push1_data%0d", i), bq_data[i], e1[i]);
        end
        check_eq("push1_spwr", 32'(sp_wr), 32'd1);
        check_eq("push1_wsp", sp_val, base);
        check_eq("push1_lat", 32'(done_cyc), 32'(n + 3));
        check_eq("push1_stray", 32'(stray), 32'd0);

        // POP {R2,R4,PC}
        pop_data[0] = 32'hA; pop_data[1] = 32'hB; pop_data[2] = 32'h40;
        n = 2 + LRPC;
        run_op(1'b1, 9'h114, 32'h2000_00F4, 0);
        check_eq("pop2_beats", 32'(bq_addr.size()), 32'(n));
        for (int i = 0; i < n && i < bq_addr.size(); i++)
            check_eq($sformatf("pop2_addr%0d", i), bq_addr[i], 32'h2000_00F4 + 32'(4 * i));
        check_eq("pop2_rdcnt", 32'(rq_idx.size()), 32'd2);
        if (rq_idx.size() == 2) begin
            check_eq("pop2_rd0", {rq_idx[0], rq_val[0][27:0]}, {4'd2, 28'hA});
            check_eq("pop2_rd1", {rq_idx[1], rq_val[1][27:0]}, {4'd4, 28'hB});
        end
        check_eq("pop2_pcld", 32'(pc_ld), 32'(LRPC));
        check_eq("pop2_wpc", pc_val, (LRPC != 0) ? 32'h40 : 32'h0);
        check_eq("pop2_wsp", sp_val, 32'h2000_00F4 + 32'(4 * n));
        check_eq("pop2_lat", 32'(done_cyc), 32'(n + 3));
        check_eq("pop2_stray", 32'(stray), 32'd0);

        // Empty list
        run_op(1'b0, 9'h000, 32'h2000_0040, 0);
        check_eq("empty_lat", 32'(done_cyc), 32'd2);
        check_eq("empty_req", 32'(req_cyc), 32'd0);
        check_eq("empty_spwr", 32'(sp_wr), 32'd0);

        // PUSH {R3}, ack after 3 wait cycles
        run_op(1'b0, 9'h008, 32'h2000_0200, 3);
        check_eq("wait_req", 32'(req_cyc), 32'd4);
        check_eq("wait_hold", 32'(hold_err), 32'd0);
        check_eq("wait_beats", 32'(bq_addr.size()), 32'd1);
        if (bq_addr.size() == 1) begin
            check_eq("wait_addr", bq_addr[0], 32'h2000_01FC);
            check_eq("wait_data", bq_data[0], 32'h33);
        end
        check_eq("wait_wsp", sp_val, 32'h2000_01FC);
        check_eq("wait_lat", 32'(done_cyc), 32'd7);

        // POP of a full list
        foreach (pop_data[i]) pop_data[i] = 32'h100 + 32'(i);
        n = 8 + LRPC;
        run_op(1'b1, 9'h1FF, 32'h2000_1000, 0);
        check_eq("popall_beats", 32'(bq_addr.size()), 32'(n));
        check_eq("popall_rdcnt", 32'(rq_idx.size()), 32'd8);
        bad = 0;
        for (int i = 0; i < rq_idx.size(); i++)
            if (rq_idx[i] !== 4'(i) || rq_val[i] !== 32'h100 + 32'(i)) bad++;
        check_eq("popall_order", 32'(bad), 32'd0);
        check_eq("popall_pcld", 32'(pc_ld), 32'(LRPC));
        check_eq("popall_wsp", sp_val, 32'h2000_1000 + 32'(4 * n));
        check_eq("popall_lat", 32'(done_cyc), 32'(n + 3));

        // Reset during second beat of PUSH {R0-R7}
        start = 1'b1; is_pop = 1'b0; reg_list = 9'h0FF; sp_in = 32'h2000_0100;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_eq("rstmid_beat2", mem_addr, 32'h2000_00E4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rstmid_ctrl", {24'd0, busy, done, mem_req, mem_we, ld_rd, ld_pc, branch, ld_sp}, 32'd0);
        check_eq("rstmid_addr", mem_addr | {28'd0, addr_Rm}, 32'd0);
        check_eq("rstmid_data", mem_wdata | w_SP, 32'd0);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ld_sp || mem_req || busy) bad++;
        end
        check_eq("rstmid_quiet", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
